// File: rtl/rx_pkg.sv
// -----------------------------------------------------------------------------
// rx_pkg
// Shared constants and helpers for the 802.11a receive chain.
//   - N_CBPS / N_BPSC values for each rate, plus the QPSK defaults
//   - calc_s():     column-rotation step s = max(N_BPSC/2, 1)
//   - deint_addr(): received index j -> natural-order write address k
//   - rd_state_t:   read FSM state encoding for the ping-pong deinterleaver
// -----------------------------------------------------------------------------
package rx_pkg;

  localparam int N_CBPS_BPSK  = 48;
  localparam int N_CBPS_QPSK  = 96;
  localparam int N_CBPS_16QAM = 192;
  localparam int N_CBPS_64QAM = 288;

  localparam int N_BPSC_BPSK  = 1;
  localparam int N_BPSC_QPSK  = 2;
  localparam int N_BPSC_16QAM = 4;
  localparam int N_BPSC_64QAM = 6;

  function automatic int calc_s(input int n_bpsc);
    return ((n_bpsc / 2) > 1) ? (n_bpsc / 2) : 1;
  endfunction

  localparam int DEF_N_CBPS = N_CBPS_QPSK;
  localparam int DEF_N_BPSC = N_BPSC_QPSK;
  localparam int S          = calc_s(DEF_N_BPSC);

  // Undo the second permutation (bit rotation inside a subcarrier group),
  // then the first one (16-column block write / row read).
  function automatic int deint_addr(input int j, input int n_cbps, input int s);
    int i;
    i = s * (j / s) + ((j + (16 * j) / n_cbps) % s);
    return 16 * i - (n_cbps - 1) * ((16 * i) / n_cbps);
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_t;

endpackage

// File: rtl/deint_addr_gen.sv
// -----------------------------------------------------------------------------
// deint_addr_gen
// Maps the write counter (received coded-bit index) to the bank address that
// holds that bit in natural coded-bit order. The table is fully constant and
// folds into a small combinational ROM.
// Ports:
//   wcnt  in   received index j, 0..N_CBPS-1
//   addr  out  write address k in natural order
// -----------------------------------------------------------------------------
module deint_addr_gen
  import rx_pkg::*;
#(
  parameter int N_CBPS = DEF_N_CBPS,
  parameter int N_BPSC = DEF_N_BPSC
) (
  input  logic [$clog2(N_CBPS)-1:0] wcnt,
  output logic [$clog2(N_CBPS)-1:0] addr
);

  localparam int AW    = $clog2(N_CBPS);
  localparam int S_LOC = calc_s(N_BPSC);

  logic [AW-1:0] rom [N_CBPS];

  for (genvar g = 0; g < N_CBPS; g++) begin : g_rom
    assign rom[g] = AW'(deint_addr(g, N_CBPS, S_LOC));
  end

  assign addr = rom[wcnt];

endmodule

// File: rtl/deinterleaver_pingpong.sv
// -----------------------------------------------------------------------------
// deinterleaver_pingpong
// 802.11a block deinterleaver in front of the Viterbi decoder. Coded bits are
// written serially into one of two banks at their natural-order address; a
// full bank is replayed as one uninterrupted burst of N_CBPS bits while the
// other bank fills.
// Ports:
//   Clk          in   clock, rising edge
//   Reset        in   synchronous active-high reset
//   Data         in   received coded bit (interleaved order)
//   In_Valid     in   Data valid this cycle
//   Out_Ready    in   downstream accepts a new block (checked only at burst start)
//   Out          out  deinterleaved coded bit
//   Out_Valid    out  high for N_CBPS consecutive cycles per block
//   Block_Start  out  pulse on the first bit of each burst
//   Overflow     out  sticky: a bit was dropped because both banks were full
// -----------------------------------------------------------------------------
module deinterleaver_pingpong
  import rx_pkg::*;
#(
  parameter int N_CBPS = DEF_N_CBPS,
  parameter int N_BPSC = DEF_N_BPSC
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Data,
  input  logic In_Valid,
  input  logic Out_Ready,
  output logic Out,
  output logic Out_Valid,
  output logic Block_Start,
  output logic Overflow
);

  localparam int            AW   = $clog2(N_CBPS);
  localparam logic [AW-1:0] LAST = AW'(N_CBPS - 1);

  logic          mem0 [N_CBPS];
  logic          mem1 [N_CBPS];
  logic [AW-1:0] wcnt, waddr, rcnt, ridx;
  logic          wbank, rbank, rd_sel, rd_bit, we;
  logic [1:0]    full;
  rd_state_t     state, state_next;
  logic          load_first, chain, advance, finish;

  deint_addr_gen #(
    .N_CBPS (N_CBPS),
    .N_BPSC (N_BPSC)
  ) u_addr (
    .wcnt (wcnt),
    .addr (waddr)
  );

  // Read FSM: next state and per-cycle read actions.
  always_comb begin
    state_next = state;
    load_first = 1'b0;
    chain      = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (full[rbank] && Out_Ready) begin
          state_next = BURST;
          load_first = 1'b1;
        end
      end
      BURST: begin
        if (rcnt == LAST) begin
          finish = 1'b1;
          if (full[~rbank] && Out_Ready) chain = 1'b1;
          else                           state_next = IDLE;
        end else begin
          advance = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // A bank being freed this edge may already take the first bit of the next
  // symbol; the full flag is cleared at the same edge.
  assign we = In_Valid && (!full[wbank] || (finish && (rbank == wbank)));

  // Bit to present next: bit 0 of the bank starting a burst, else rcnt+1.
  always_comb begin
    rd_sel = rbank;
    ridx   = '0;
    if (chain)        rd_sel = ~rbank;
    else if (advance) ridx   = rcnt + 1'b1;
    rd_bit = rd_sel ? mem1[ridx] : mem0[ridx];
  end

  // ---- write stage: bank storage ----
  always_ff @(posedge Clk) begin
    if (we) begin
      if (wbank) mem1[waddr] <= Data;
      else       mem0[waddr] <= Data;
    end
  end

  // Write control and bank-full flags. The set is placed after the clear so
  // a completion always wins over a release in the same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wcnt     <= '0;
      wbank    <= 1'b0;
      full     <= 2'b00;
      Overflow <= 1'b0;
    end else begin
      if (finish) full[rbank] <= 1'b0;
      if (we) begin
        if (wcnt == LAST) begin
          wcnt        <= '0;
          wbank       <= ~wbank;
          full[wbank] <= 1'b1;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end
      if (In_Valid && !we) Overflow <= 1'b1;
    end
  end

  // ---- read stage: registered serial output ----
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Out         <= 1'b0;
      Out_Valid   <= 1'b0;
      Block_Start <= 1'b0;
      rcnt        <= '0;
      rbank       <= 1'b0;
    end else begin
      Block_Start <= load_first || chain;
      if (load_first || chain) begin
        Out       <= rd_bit;
        Out_Valid <= 1'b1;
        rcnt      <= '0;
      end else if (advance) begin
        Out  <= rd_bit;
        rcnt <= rcnt + 1'b1;
      end else if (finish) begin
        Out       <= 1'b0;
        Out_Valid <= 1'b0;
      end
      if (finish) rbank <= ~rbank;
    end
  end

endmodule

// File: tb/tb_deinterleaver_pingpong.sv
// -----------------------------------------------------------------------------
// tb_deinterleaver_pingpong
// Directed bench for the ping-pong deinterleaver: a QPSK instance (96 bits)
// and a BPSK instance (48 bits). Expected output bits are computed from the
// address map when a symbol is sent and queued; monitors pop and compare.
// -----------------------------------------------------------------------------
module tb_deinterleaver_pingpong;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic q_rst, q_data, q_iv, q_rdy, q_out, q_ov, q_bs, q_of;
  logic b_rst, b_data, b_iv, b_rdy, b_out, b_ov, b_bs, b_of;

  deinterleaver_pingpong #(.N_CBPS(96), .N_BPSC(2)) dut_q (
    .Clk(clk), .Reset(q_rst), .Data(q_data), .In_Valid(q_iv), .Out_Ready(q_rdy),
    .Out(q_out), .Out_Valid(q_ov), .Block_Start(q_bs), .Overflow(q_of)
  );

  deinterleaver_pingpong #(.N_CBPS(48), .N_BPSC(1)) dut_b (
    .Clk(clk), .Reset(b_rst), .Data(b_data), .In_Valid(b_iv), .Out_Ready(b_rdy),
    .Out(b_out), .Out_Valid(b_ov), .Block_Start(b_bs), .Overflow(b_of)
  );

  typedef struct {
    bit v;
    bit st;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_b[$];
  exp_t e_q, e_b;
  int   compared   = 0;
  int   mismatched = 0;
  bit   mon_en     = 1'b1;
  bit   sym [96];
  int   pos_q, run_q, last_run_q, bs_cnt_q;
  int   pos_b, run_b, last_run_b;
  int   ones_q[$];
  int   ones_b[$];

  task automatic check(input string tag, input int obs, input int expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Address map written out from the two-step permutation definition.
  function automatic int tb_k(input int j, input int n, input int nbpsc);
    int s, i;
    s = (nbpsc / 2 > 1) ? nbpsc / 2 : 1;
    i = s * (j / s) + ((j + (16 * j) / n) % s);
    return 16 * i - (n - 1) * ((16 * i) / n);
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (q_ov) begin
        if (q_bs) begin pos_q = 0; bs_cnt_q++; end
        else pos_q++;
        run_q++;
        if (q_out) ones_q.push_back(pos_q);
        check("q_unexpected_out", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          e_q = exp_q.pop_front();
          check("q_out_bit", q_out, e_q.v);
          check("q_block_start", q_bs, e_q.st);
        end
      end else begin
        if (run_q != 0) last_run_q = run_q;
        run_q = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (b_ov) begin
      if (b_bs) pos_b = 0;
      else pos_b++;
      run_b++;
      if (b_out) ones_b.push_back(pos_b);
      check("b_unexpected_out", (exp_b.size() > 0) ? 1 : 0, 1);
      if (exp_b.size() > 0) begin
        e_b = exp_b.pop_front();
        check("b_out_bit", b_out, e_b.v);
        check("b_block_start", b_bs, e_b.st);
      end
    end else begin
      if (run_b != 0) last_run_b = run_b;
      run_b = 0;
    end
  end

  task automatic clear_sym();
    for (int j = 0; j < 96; j++) sym[j] = 1'b0;
  endtask

  task automatic rand_sym();
    for (int j = 0; j < 96; j++) sym[j] = 1'($urandom_range(0, 1));
  endtask

  // Send sym[0..n-1] to instance `which` (0 = QPSK, 1 = BPSK), queue the
  // expected burst, and optionally check first-bit latency.
  task automatic send_sym(input int which, input int n, input int nbpsc,
                          input bit gap, input bit chk_lat);
    bit expv [96];
    for (int j = 0; j < n; j++) begin
      if (gap && j > 0) begin @(posedge clk); #1; end
      if (which == 0) begin q_data = sym[j]; q_iv = 1'b1; end
      else            begin b_data = sym[j]; b_iv = 1'b1; end
      @(posedge clk); #1;
      q_iv = 1'b0;
      b_iv = 1'b0;
    end
    for (int j = 0; j < n; j++) expv[tb_k(j, n, nbpsc)] = sym[j];
    for (int k = 0; k < n; k++) begin
      if (which == 0) exp_q.push_back('{v: expv[k], st: (k == 0)});
      else            exp_b.push_back('{v: expv[k], st: (k == 0)});
    end
    if (chk_lat) begin
      check("lat_not_yet_valid", (which == 0) ? q_ov : b_ov, 0);
      @(posedge clk); #1;
      check("lat_first_valid", (which == 0) ? q_ov : b_ov, 1);
      check("lat_block_start", (which == 0) ? q_bs : b_bs, 1);
    end
  endtask

  task automatic send_extra(input int cnt);
    for (int j = 0; j < cnt; j++) begin
      q_data = 1'($urandom_range(0, 1));
      q_iv   = 1'b1;
      @(posedge clk); #1;
      q_iv = 1'b0;
    end
  endtask

  task automatic wait_done(input int which, input int budget);
    int c = 0;
    while (c < budget &&
           ((which == 0) ? (exp_q.size() > 0 || q_ov) : (exp_b.size() > 0 || b_ov))) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk); #1;
    check("drain_within_budget", (c < budget) ? 1 : 0, 1);
  endtask

  initial begin
    q_rst = 1'b1; q_data = 1'b0; q_iv = 1'b0; q_rdy = 1'b1;
    b_rst = 1'b1; b_data = 1'b0; b_iv = 1'b0; b_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_q_out", q_out, 0);
    check("rst_q_valid", q_ov, 0);
    check("rst_q_bs", q_bs, 0);
    check("rst_q_ovf", q_of, 0);
    check("rst_b_out", b_out, 0);
    check("rst_b_valid", b_ov, 0);
    check("rst_b_bs", b_bs, 0);
    check("rst_b_ovf", b_of, 0);
    q_rst = 1'b0;
    b_rst = 1'b0;
    @(posedge clk); #1;

    // QPSK single 1 at j=6 -> position 1
    clear_sym(); sym[6] = 1'b1;
    ones_q.delete();
    send_sym(0, 96, 2, 1'b0, 1'b1);
    wait_done(0, 300);
    check("q_j6_count", ones_q.size(), 1);
    if (ones_q.size() == 1) check("q_j6_pos", ones_q[0], 1);
    check("q_single_run", last_run_q, 96);

    // QPSK j=1 -> 16, j=95 -> 95
    clear_sym(); sym[1] = 1'b1; sym[95] = 1'b1;
    ones_q.delete();
    send_sym(0, 96, 2, 1'b0, 1'b1);
    wait_done(0, 300);
    check("q_j1_j95_count", ones_q.size(), 2);
    if (ones_q.size() == 2) begin
      check("q_j1_pos", ones_q[0], 16);
      check("q_j95_pos", ones_q[1], 95);
    end

    // BPSK j=3 -> 1, then j=1 -> 16
    clear_sym(); sym[3] = 1'b1;
    ones_b.delete();
    send_sym(1, 48, 1, 1'b0, 1'b1);
    wait_done(1, 200);
    check("b_j3_count", ones_b.size(), 1);
    if (ones_b.size() == 1) check("b_j3_pos", ones_b[0], 1);
    check("b_run", last_run_b, 48);
    clear_sym(); sym[1] = 1'b1;
    ones_b.delete();
    send_sym(1, 48, 1, 1'b0, 1'b1);
    wait_done(1, 200);
    check("b_j1_count", ones_b.size(), 1);
    if (ones_b.size() == 1) check("b_j1_pos", ones_b[0], 16);

    // Back-to-back: three QPSK symbols streamed continuously
    bs_cnt_q = 0;
    for (int n = 0; n < 3; n++) begin
      rand_sym();
      send_sym(0, 96, 2, 1'b0, 1'b0);
    end
    wait_done(0, 600);
    check("b2b_run", last_run_q, 288);
    check("b2b_block_starts", bs_cnt_q, 3);
    check("b2b_overflow", q_of, 0);

    // Gapped input: In_Valid toggles every cycle
    rand_sym();
    send_sym(0, 96, 2, 1'b1, 1'b1);
    wait_done(0, 300);
    check("gap_run", last_run_q, 96);

    // Overflow: two symbols plus five bits with Out_Ready low
    q_rdy = 1'b0;
    rand_sym();
    send_sym(0, 96, 2, 1'b0, 1'b0);
    rand_sym();
    send_sym(0, 96, 2, 1'b0, 1'b0);
    send_extra(5);
    @(posedge clk); #1;
    check("ovf_set", q_of, 1);
    check("ovf_held_off", q_ov, 0);
    q_rdy = 1'b1;
    wait_done(0, 600);
    check("ovf_two_bursts_run", last_run_q, 192);
    repeat (20) @(negedge clk);
    #1;
    check("ovf_no_extra", q_ov, 0);
    check("ovf_sticky", q_of, 1);

    // Reset at burst bit 40
    rand_sym();
    send_sym(0, 96, 2, 1'b0, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    mon_en = 1'b0;
    exp_q.delete();
    q_rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_valid", q_ov, 0);
    check("rst_mid_out", q_out, 0);
    check("rst_mid_bs", q_bs, 0);
    check("rst_mid_ovf", q_of, 0);
    q_rst = 1'b0;
    run_q = 0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_idle", q_ov, 0);

    // Fresh symbol after reset
    rand_sym();
    send_sym(0, 96, 2, 1'b0, 1'b1);
    wait_done(0, 300);
    check("post_rst_run", last_run_q, 96);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule

// File: doc/deinterleaver_pingpong.md
Name: deinterleaver_pingpong

Overview:
- 802.11a receive-chain block directly upstream of the Viterbi decoder.
- Accepts demapped coded bits serially, one bit per clock when In_Valid is high, and collects one OFDM symbol of N_CBPS bits.
- Undoes the two-step 802.11a block interleaving permutation.
- Replays each symbol as a contiguous serial burst in natural coded-bit order. Out_Valid drives the decoder's EN and Out drives its Data.
- Uses two banks (ping-pong): one bank fills while the other drains.

Parameters:
- N_CBPS, 96, coded bits per OFDM symbol (48/96/192/288). It equals the decoder's input block size.
- N_BPSC, 2, coded bits per subcarrier (1/2/4/6). Sets s = max(N_BPSC/2,1).

Ports:
- Clk  in  1  system clock, rising-edge.
- Reset  in  1  synchronous, active-high reset.
- Data  in  1  received coded bit, in interleaved order.
- In_Valid  in  1  Data is valid this cycle.
- Out_Ready  in  1  downstream can accept a new block. Sampled only when a burst is about to start.
- Out  out  1  deinterleaved coded bit.
- Out_Valid  out  1  Out is valid. High for exactly N_CBPS consecutive cycles per block.
- Block_Start  out  1  one-cycle pulse on the first bit of each burst.
- Overflow  out  1  sticky: input bit dropped because both banks were full.

Behaviour:
- Interface: one clock (Clk); reset is synchronous and active-high (Reset).
- Reset values: Out=0, Out_Valid=0, Block_Start=0, Overflow=0. Write/read counters=0, write bank=0, both bank-full flags=0. Reset mid-operation discards partial and full blocks.
- Address map: received index j (0..N_CBPS-1) maps to write address k, computed in two steps.
  - i = s*floor(j/s) + (j + floor(16*j/N_CBPS)) mod s
  - k = 16*i - (N_CBPS-1)*floor(16*i/N_CBPS)
- Write path:
  - On Clk with In_Valid=1 and the write bank not full: bank[wbank][k(wcnt)] <= Data, and wcnt increments.
  - When wcnt = N_CBPS-1 is written: wcnt wraps to 0, full[wbank] is set, and wbank toggles in the same edge.
  - If In_Valid=1 while full[wbank]=1: the bit is dropped, wcnt is held, and Overflow is set. Overflow clears only on Reset.
- Read FSM, states IDLE and BURST:
  - IDLE -> BURST when full[rbank]=1 and Out_Ready=1. From the following cycle, Out = bank[rbank][rcnt] with rcnt = 0..N_CBPS-1 and Out_Valid=1. Block_Start=1 on rcnt=0 only.
  - BURST ignores Out_Ready; the burst is never interrupted.
  - After rcnt = N_CBPS-1 is output: full[rbank] clears and rbank toggles.
    - If the other bank is full and Out_Ready=1, the next burst starts on the very next cycle: Out_Valid stays high and Block_Start pulses.
    - Otherwise the FSM returns to IDLE and Out_Valid goes 0.
- Latency: the last bit of a symbol is captured at edge T. With Out_Ready=1 and the read side idle, Out_Valid=1 and bit 0 appear in cycle T+1. The block ends at cycle T+N_CBPS.
- Same-bank write and clear in one edge: freeing a bank (end of burst) and the first write into it may coincide. The write is accepted, because the full flag clears at that edge; write-then-read ordering still holds.
- In_Valid gaps mid-symbol are allowed; wcnt simply holds.
- Outputs are registered; there is no combinational path from Data or In_Valid to any output.

Decomposition:
- Shared package `rx_pkg`:
  - N_CBPS / N_BPSC defaults per rate.
  - Derived constant S.
  - Constant function `deint_addr(j, N_CBPS, S)`.
  - Read-FSM state encoding: IDLE=1'b0, BURST=1'b1.
- Sub-module `deint_addr_gen`: maps wcnt to write address k, either as a combinational ROM built from `deint_addr` or as an incremental computation.
- The top level holds the banks, counters, full flags and read FSM.

Test Plan:
- QPSK (N_CBPS=96, N_BPSC=2): send a single 1 at received index j=6, all other bits 0. Out_Ready=1 -> one burst of 96 with Out=1 only at output position 1. Index j=1 lands at position 16; j=95 lands at position 95.
- BPSK (N_CBPS=48, N_BPSC=1): 1 at j=3 -> Out=1 only at position 1; 1 at j=1 -> position 16. Out_Valid high exactly 48 cycles, first bit at T+1.
- Back-to-back (QPSK): 3 symbols streamed continuously with Out_Ready=1 -> 288 contiguous Out_Valid cycles, Block_Start at cycles 0, 96 and 192 of the stream, contents correct per symbol, Overflow=0.
- Overflow: Out_Ready=0 while 2 full symbols plus 5 more valid bits are sent -> Overflow=1. Raise Out_Ready -> the first two symbols are output intact and the extra 5 bits are absent.
- Reset mid-burst: assert Reset at burst bit 40 -> next cycle Out_Valid=0, Out=0, Block_Start=0, Overflow=0. A fresh symbol afterwards decodes correctly from index 0.
- Gapped input: In_Valid toggles 1/0 every cycle for one QPSK symbol -> same output as the contiguous case; burst starts one cycle after the 96th valid bit.
